// File: rtl/coin_change_dispenser_pkg.sv
// Shared definitions for the coin change dispenser: coin codes, unit values, FSM states.
// Latency: none (declarations only).
// Backpressure: not applicable.
package coin_change_dispenser_pkg;

  // Hopper coin codes; 2'b11 is reserved and never driven.
  localparam logic [1:0] COIN_25C   = 2'b00;
  localparam logic [1:0] COIN_50C   = 2'b01;
  localparam logic [1:0] COIN_1BIRR = 2'b10;

  // Coin values in 25-cent units.
  localparam logic [2:0] UNITS_25C   = 3'd1;
  localparam logic [2:0] UNITS_50C   = 3'd2;
  localparam logic [2:0] UNITS_1BIRR = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CALC     = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

endpackage

// File: rtl/coin_change_dispenser_coin_select.sv
// Greedy coin picker: largest coin that does not exceed the amount still owed.
// Latency: purely combinational.
// Backpressure: none; output is a pure function of the amount.
module coin_select #(
  parameter int UNIT_W = 4
) (
  input  logic [UNIT_W-1:0] remaining_i,
  output logic [1:0]        coin_type_o,
  output logic [2:0]        coin_value_o
);
  import coin_change_dispenser_pkg::*;

  // Compare at 32 bits so the coin values never get truncated by a narrow UNIT_W.
  always_comb begin
    coin_type_o  = COIN_25C;
    coin_value_o = UNITS_25C;
    if (32'(remaining_i) >= 32'(UNITS_1BIRR)) begin
      coin_type_o  = COIN_1BIRR;
      coin_value_o = UNITS_1BIRR;
    end else if (32'(remaining_i) >= 32'(UNITS_50C)) begin
      coin_type_o  = COIN_50C;
      coin_value_o = UNITS_50C;
    end
  end

endmodule

// File: rtl/coin_change_dispenser.sv
// Pays change (or a full refund when credit is short) to the hopper, largest coin first.
// Latency: start -> first coin 2 cycles, 1 cycle per accepted coin, done 1 cycle after last coin.
// Backpressure: coin_valid/coin_type/remaining hold while coin_ready is low.
module coin_change_dispenser #(
  parameter int UNIT_W = 4
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              start,
  input  logic [UNIT_W-1:0] credit,
  input  logic [UNIT_W-1:0] price,
  input  logic              coin_ready,
  output logic              coin_valid,
  output logic [1:0]        coin_type,
  output logic              busy,
  output logic              done,
  output logic              refund,
  output logic [UNIT_W-1:0] remaining
);
  import coin_change_dispenser_pkg::*;

  state_t            state_q, state_d;
  logic [UNIT_W-1:0] credit_q, credit_d;
  logic [UNIT_W-1:0] price_q, price_d;
  logic [UNIT_W-1:0] remaining_q, remaining_d;
  logic              refund_q, refund_d;
  logic [1:0]        coin_type_q, coin_type_d;
  logic [2:0]        coin_value_q, coin_value_d;
  logic              coin_valid_q;
  logic              done_q;

  logic [1:0]        sel_type;
  logic [2:0]        sel_value;

  // The picker looks at the amount that will be owed after this edge, so the
  // registered coin always matches the registered remaining.
  coin_select #(.UNIT_W(UNIT_W)) u_coin_select (
    .remaining_i  (remaining_d),
    .coin_type_o  (sel_type),
    .coin_value_o (sel_value)
  );

  // Next-state and datapath update for the payout FSM.
  always_comb begin
    state_d      = state_q;
    credit_d     = credit_q;
    price_d      = price_q;
    remaining_d  = remaining_q;
    refund_d     = refund_q;
    coin_type_d  = coin_type_q;
    coin_value_d = coin_value_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          credit_d = credit;
          price_d  = price;
          refund_d = (credit < price);
          state_d  = ST_CALC;
        end
      end
      ST_CALC: begin
        refund_d    = (credit_q < price_q);
        remaining_d = (credit_q >= price_q) ? (credit_q - price_q) : credit_q;
        if (remaining_d == '0) begin
          state_d = ST_DONE;
        end else begin
          state_d      = ST_DISPENSE;
          coin_type_d  = sel_type;
          coin_value_d = sel_value;
        end
      end
      ST_DISPENSE: begin
        if (coin_ready) begin
          // Greedy choice never exceeds remaining, so this cannot wrap.
          remaining_d = remaining_q - UNIT_W'(coin_value_q);
          if (remaining_d == '0) begin
            state_d = ST_DONE;
          end else begin
            coin_type_d  = sel_type;
            coin_value_d = sel_value;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset wins over everything, including a coin in flight.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      credit_q     <= '0;
      price_q      <= '0;
      remaining_q  <= '0;
      refund_q     <= 1'b0;
      coin_type_q  <= COIN_25C;
      coin_value_q <= UNITS_25C;
      coin_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      credit_q     <= credit_d;
      price_q      <= price_d;
      remaining_q  <= remaining_d;
      refund_q     <= refund_d;
      coin_type_q  <= coin_type_d;
      coin_value_q <= coin_value_d;
      coin_valid_q <= (state_d == ST_DISPENSE);
      done_q       <= (state_d == ST_DONE);
    end
  end

  assign coin_valid = coin_valid_q;
  assign coin_type  = coin_type_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign refund     = refund_q;
  assign remaining  = remaining_q;

endmodule

// File: doc/coin_change_dispenser.md
# coin_change_dispenser

Return-path block for the switch-driven coin vending machine: the existing front end accepts 25-cent, 50-cent and 1-birr coins and accumulates credit. This block pays money back out. It takes a credit and price snapshot, computes change, or a full refund when credit is short, and drives a coin hopper one coin at a time over a valid/ready handshake, largest coin first. Status outputs go to LEDR and the 7-segment path.

## Interface
Parameters:
- UNIT_W, default 4: width of credit, price and remaining, counted in 25-cent units (1 birr = 4 units).

Ports:
- CLOCK_50, input, 1: the single clock. All state changes on its rising edge.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: one-cycle request. Sampled only in IDLE.
- credit, input, UNIT_W: inserted credit in units. Sampled with start.
- price, input, UNIT_W: item price in units. Sampled with start.
- coin_ready, input, 1: hopper accepts the presented coin.
- coin_valid, output, 1: a coin is presented to the hopper.
- coin_type, output, 2: coin code. 00 = 25c, 01 = 50c, 10 = 1 birr. 11 is never driven.
- busy, output, 1: high in every state except IDLE.
- done, output, 1: one-cycle pulse when the transaction completes.
- refund, output, 1: registered at start. Set when credit < price. Held until the next accepted start.
- remaining, output, UNIT_W: units still to be paid out.

Reset values: coin_valid=0, coin_type=00, busy=0, done=0, refund=0, remaining=0, state=IDLE.

## Operation
- States: IDLE, CALC, DISPENSE, DONE.
- IDLE: when start=1, latch credit and price, then go to CALC. start is ignored in all other states.
- CALC (1 cycle):
  - If credit ≥ price: remaining = credit − price, refund = 0.
  - Otherwise: remaining = credit, refund = 1.
  - Next state: DONE if remaining = 0, else DISPENSE.
  - On entry to DISPENSE, coin_valid=1 and coin_type is the greedy choice for the new remaining.
- Greedy choice:
  - remaining ≥ 4 → 1 birr.
  - remaining ≥ 2 → 50c.
  - remaining ≥ 1 → 25c.
- DISPENSE:
  - coin_valid stays 1 while coin_ready=0; coin_type and remaining hold stable.
  - A handshake (coin_valid & coin_ready) subtracts the coin value (4, 2 or 1) from remaining.
  - If the new remaining > 0: coin_type updates to the next greedy choice on the same edge and coin_valid stays 1, so transfers can go back-to-back.
  - If the new remaining = 0: coin_valid drops to 0 and the state moves to DONE.
- DONE (1 cycle): done=1, then IDLE. refund and remaining keep their final values; remaining is 0.
- Arithmetic: subtraction is unsigned at UNIT_W bits. The greedy rule never subtracts more than remaining, so remaining cannot underflow.

## Timing
- start at edge N puts the state in CALC at N+1. coin_valid is high from N+2, or done is high at N+2 when no change is due.
- Each coin needs at least 1 cycle. With coin_ready held high, k coins take k cycles, then done follows 1 cycle after the last handshake.
- Zero-change latency from start to the done pulse is 2 cycles.
- reset overrides everything on the same edge, including mid-DISPENSE. The coin in flight is abandoned and all outputs return to reset values on the next edge. start in the reset cycle is ignored.
- coin_ready while coin_valid=0 is ignored.
- credit = price = 0 follows the zero-change path: done, no coins, refund=0.
- Maximum credit (2^UNIT_W − 1) with price 0 must dispense correctly. For UNIT_W=4, 15 units = 1 birr ×3, 50c, 25c.

## Structure
- Shared package holds:
  - coin codes COIN_25C = 2'b00, COIN_50C = 2'b01, COIN_1BIRR = 2'b10;
  - unit values 1, 2, 4;
  - the FSM state encoding.
- Sub-module coin_select: purely combinational. Maps remaining to {coin_type, coin_value}. It is instantiated once and feeds both the CALC and DISPENSE updates.
- Top level: FSM plus credit/price latch, remaining register and output registers.

## Test plan
- Change with back-to-back coins: credit=7, price=2, coin_ready held 1 → coins 1 birr then 25c on consecutive cycles, remaining 5→1→0, done one cycle later, refund=0.
- Exact payment: credit=3, price=3 → no coin_valid; done exactly 2 cycles after start; busy high for cycles N+1 and N+2.
- Short credit: credit=2, price=5 → refund=1, a single 50c coin, done pulse, refund still 1 in IDLE afterwards.
- Backpressure: credit=15, price=0, coin_ready low for 5 cycles on the second coin → coin_valid and coin_type=10 held stable. Full sequence is 10, 10, 10, 01, 00; remaining ends at 0.
- Reset mid-dispense: reset asserted during the third coin of credit=15 → next edge shows coin_valid=0, busy=0, remaining=0, state IDLE. A following start with credit=1, price=0 gives a single 25c coin.
- start while busy: a second start, pulsed with credit=9, during DISPENSE → ignored; the original transaction's coin sequence is unchanged.
